// File: rtl/video_out_param.sv
// Composite data-tape video output: pixel/line/field timing, vertical-interval sync shapes,
// per-field preamble lines and symbol-to-DAC-level conversion from a show-ahead FIFO.
module video_out_param #(
    parameter int LINE_CLKS      = 400,
    parameter int HSYNC_CLKS     = 29,
    parameter int EQ_CLKS        = 13,
    parameter int SERR_CLKS      = 30,
    parameter int ACTIVE_START   = 58,
    parameter int ACTIVE_LEN     = 331,
    parameter int FIELD0_LINES   = 263,
    parameter int FIELD1_LINES   = 262,
    parameter int BLANK_LINES    = 19,
    parameter int PREAMBLE_LINES = 1,
    parameter int SYM_BITS       = 4,
    parameter int DAC_W          = 8,
    parameter int LEVEL_BLANK    = 41,
    parameter int LEVEL_PAD      = 56,
    parameter int LEVEL_BASE     = 100,
    parameter int LEVEL_STEP     = 10
) (
    input  logic                clk,
    input  logic                rst,
    output logic [DAC_W-1:0]    video,
    output logic                sync,
    input  logic [SYM_BITS-1:0] fifo_data,
    input  logic                fifo_empty,
    output logic                fifo_rd,
    output logic                field,
    output logic                line_start,
    output logic [15:0]         underrun_count
);

    localparam int MAX_LINES = (FIELD0_LINES > FIELD1_LINES) ? FIELD0_LINES : FIELD1_LINES;
    localparam int PIX_W     = $clog2(LINE_CLKS + 1);
    localparam int LINE_W    = $clog2(MAX_LINES + 1);
    localparam int HALF      = LINE_CLKS / 2;
    localparam int LVL_W     = DAC_W + SYM_BITS + 1;

    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'((1 << DAC_W) - 1);

    // Linear symbol level, saturated to the DAC full scale.
    function automatic logic [DAC_W-1:0] level(input logic [SYM_BITS-1:0] s);
        logic [LVL_W-1:0] v;
        v = LVL_W'(LEVEL_BASE) + LVL_W'(LEVEL_STEP) * LVL_W'(s);
        if (v > LVL_MAX)
            return {DAC_W{1'b1}};
        return v[DAC_W-1:0];
    endfunction

    localparam logic [DAC_W-1:0] LVL_BLANK = DAC_W'(LEVEL_BLANK);
    localparam logic [DAC_W-1:0] LVL_PAD   = DAC_W'(LEVEL_PAD);
    localparam logic [DAC_W-1:0] LVL_LO    = level({SYM_BITS{1'b0}});
    localparam logic [DAC_W-1:0] LVL_HI    = level({SYM_BITS{1'b1}});

    localparam logic [PIX_W-1:0] P_LAST    = PIX_W'(LINE_CLKS - 1);
    localparam logic [PIX_W-1:0] P_EQ      = PIX_W'(EQ_CLKS);
    localparam logic [PIX_W-1:0] P_HALF    = PIX_W'(HALF);
    localparam logic [PIX_W-1:0] P_HALF_EQ = PIX_W'(HALF + EQ_CLKS);
    localparam logic [PIX_W-1:0] P_SERR1   = PIX_W'(HALF - SERR_CLKS);
    localparam logic [PIX_W-1:0] P_SERR2   = PIX_W'(LINE_CLKS - SERR_CLKS);
    localparam logic [PIX_W-1:0] P_HS      = PIX_W'(HSYNC_CLKS);
    localparam logic [PIX_W-1:0] P_AS      = PIX_W'(ACTIVE_START);
    localparam logic [PIX_W-1:0] P_AE      = PIX_W'(ACTIVE_START + ACTIVE_LEN);
    localparam logic             AS_ODD    = (ACTIVE_START % 2) == 1;

    localparam logic [LINE_W-1:0] L3      = LINE_W'(3);
    localparam logic [LINE_W-1:0] L6      = LINE_W'(6);
    localparam logic [LINE_W-1:0] L9      = LINE_W'(9);
    localparam logic [LINE_W-1:0] L_BLANK = LINE_W'(BLANK_LINES);
    localparam logic [LINE_W-1:0] L_DATA  = LINE_W'(BLANK_LINES + PREAMBLE_LINES);
    localparam logic [LINE_W-1:0] F0_LAST = LINE_W'(FIELD0_LINES - 1);
    localparam logic [LINE_W-1:0] F1_LAST = LINE_W'(FIELD1_LINES - 1);

    generate
        if (ACTIVE_START + ACTIVE_LEN > LINE_CLKS) begin : g_chk_window
            $error("data window extends past end of line");
        end
        if (HSYNC_CLKS >= ACTIVE_START) begin : g_chk_hsync
            $error("hsync overlaps data window");
        end
        if (BLANK_LINES < 9) begin : g_chk_blank
            $error("vertical interval shorter than equalizing/serrated lines");
        end
        if (BLANK_LINES + PREAMBLE_LINES >= FIELD0_LINES ||
            BLANK_LINES + PREAMBLE_LINES >= FIELD1_LINES) begin : g_chk_field
            $error("field too short for blanking plus preamble");
        end
    endgenerate

    logic [PIX_W-1:0]  pix;
    logic [LINE_W-1:0] line;
    logic              field_cnt;

    logic              eq_line;
    logic              serr_line;
    logic              pre_line;
    logic              data_line;
    logic              in_win;
    logic              odd_off;
    logic              rd_req;
    logic              pad;
    logic              sync_n;
    logic [DAC_W-1:0]  video_n;

    always_comb begin
        eq_line   = (line < L3) || (line >= L6 && line < L9);
        serr_line = (line >= L3) && (line < L6);
        pre_line  = (line >= L_BLANK) && (line < L_DATA);
        data_line = (line >= L_DATA);
        in_win    = (pix >= P_AS) && (pix < P_AE);
        odd_off   = pix[0] ^ AS_ODD;

        sync_n  = 1'b1;
        video_n = LVL_BLANK;
        rd_req  = 1'b0;
        pad     = 1'b0;

        if (eq_line)
            sync_n = !((pix < P_EQ) || (pix >= P_HALF && pix < P_HALF_EQ));
        else if (serr_line)
            sync_n = !((pix < P_SERR1) || (pix >= P_HALF && pix < P_SERR2));
        else
            sync_n = !(pix < P_HS);

        if (pre_line && in_win) begin
            video_n = odd_off ? LVL_HI : LVL_LO;
        end else if (data_line && in_win) begin
            if (!fifo_empty) begin
                rd_req  = 1'b1;
                video_n = level(fifo_data);
            end else begin
                pad     = 1'b1;
                video_n = LVL_PAD;
            end
        end
    end

    // Pop must vanish in the reset cycle so an aborted line never consumes a word.
    assign fifo_rd = rd_req && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            pix            <= '0;
            line           <= '0;
            field_cnt      <= 1'b0;
            video          <= LVL_BLANK;
            sync           <= 1'b1;
            field          <= 1'b0;
            line_start     <= 1'b0;
            underrun_count <= '0;
        end else begin
            video      <= video_n;
            sync       <= sync_n;
            field      <= field_cnt;
            line_start <= (pix == '0);

            if (pad && underrun_count != 16'hFFFF)
                underrun_count <= underrun_count + 16'd1;

            if (pix == P_LAST) begin
                pix <= '0;
                if (line == (field_cnt ? F1_LAST : F0_LAST)) begin
                    line      <= '0;
                    field_cnt <= !field_cnt;
                end else begin
                    line <= line + LINE_W'(1);
                end
            end else begin
                pix <= pix + PIX_W'(1);
            end
        end
    end

endmodule
